// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//
// Bus-facing receive controller for a UART. Bytes arriving from the UART
// receiver (rx_end pulse + rx_data) are queued in a small FIFO. A
// two-register bus slave exposes status and lets software pop the bytes.
// A level interrupt is raised when enabled and data or an error is pending.
//
// Parameters
//   DEPTH    receive FIFO entries (power of two, 2..16)
//   TMO_CYC  idle-timeout threshold in clk cycles (>= 2)
//
// Optional feature macro
//   UART_RX_TIMEOUT_EN  when defined, an idle timer runs while the FIFO holds
//                       data and raises TMO after TMO_CYC-1 quiet cycles.
//                       When undefined there is no timer and TMO reads 0.
//
// Ports
//   clk      in   1   single clock, rising edge
//   reset    in   1   asynchronous, active-low reset
//   rx_end   in   1   one-cycle pulse: byte received
//   rx_data  in   8   received byte, valid while rx_end=1
//   cs_      in   1   chip select, active-low
//   as_      in   1   address strobe, active-low, one cycle per access
//   rw       in   1   1=read, 0=write
//   addr     in   1   0=STATUS, 1=DATA
//   wr_data  in  32   bus write data
//   rd_data  out 32   bus read data, valid while rdy_=0, else 0
//   rdy_     out  1   bus ready, active-low
//   irq      out  1   level interrupt request
//
// Register map
//   STATUS (addr 0) read : bit0 IE, bit1 AVAIL, bit2 OVR, bit3 TMO,
//                          bits[7:4] FIFO count, others 0
//   STATUS (addr 0) write: bit0 loads IE, bit2 / bit3 write-1-to-clear
//                          OVR / TMO
//   DATA   (addr 1) read : head byte zero-extended, popped; 0 when empty
//   DATA   (addr 1) write: ignored, still acknowledged
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TMO_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_end,
  input  logic [7:0]  rx_data,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic        addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy_,
  output logic        irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // -------------------------------------------------------------------------
  // Bus handshake: an access is presented on any rising edge where cs_=0 and
  // as_=0 (the strobe acts as "valid"). The slave never stalls: rdy_ goes low
  // for exactly the following cycle with rd_data registered alongside it, and
  // rd_data is forced to 0 whenever rdy_ is high. Back-to-back strobes are
  // separate accesses, each acknowledged in its own following cycle.
  // -------------------------------------------------------------------------
  logic acc;
  logic rd_stat;
  logic rd_dat;
  logic wr_stat;

  assign acc     = ~cs_ & ~as_;
  assign rd_stat = acc &  rw & ~addr;
  assign rd_dat  = acc &  rw &  addr;
  assign wr_stat = acc & ~rw & ~addr;

  // FIFO state
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  // Control / status flags
  logic ie;
  logic ovr;
  logic tmo;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Pop happens in the access cycle of a DATA read on a non-empty FIFO.
  // Because the pop is applied before the push, a full FIFO that is being
  // popped still accepts the incoming byte and does not overflow.
  logic pop;
  logic push;
  logic drop;

  assign pop  = rd_dat & ~empty;
  assign push = rx_end & (~full | pop);
  assign drop = rx_end & full & ~pop;

  // Count field is only 4 bits wide; a 16-deep full FIFO reports 15.
  logic [3:0] cnt_field;
  assign cnt_field = (int'(count) > 15) ? 4'hF : 4'(count);

  logic [31:0] status_word;
  assign status_word = {24'h0, cnt_field, tmo, ovr, ~empty, ie};

  logic [31:0] read_word;
  always_comb begin
    read_word = 32'h0;
    if (rd_stat) begin
      read_word = status_word;
    end else if (rd_dat && !empty) begin
      read_word = {24'h0, mem[rd_ptr]};
    end
  end

  // Byte storage carries no reset: stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  // Bus response, FIFO bookkeeping, IE / OVR and interrupt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ie      <= 1'b0;
      ovr     <= 1'b0;
      rdy_    <= 1'b1;
      rd_data <= 32'h0;
      irq     <= 1'b0;
    end else begin
      rdy_    <= ~acc;
      rd_data <= read_word;

      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end

      if (wr_stat) begin
        ie <= wr_data[0];
      end

      // A new overflow wins over a simultaneous software clear.
      if (drop) begin
        ovr <= 1'b1;
      end else if (wr_stat && wr_data[2]) begin
        ovr <= 1'b0;
      end

      // Built from the current registered state, so irq trails it by a cycle.
      irq <= ie & (~empty | ovr | tmo);
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  // -------------------------------------------------------------------------
  // Idle timer: counts quiet cycles while bytes sit in the FIFO. Any push or
  // pop, or an empty FIFO, restarts it. TMO is raised on the edge where the
  // counter reaches TMO_CYC-1; the counter then holds there, so TMO is raised
  // once per idle period and a software clear sticks until the next period.
  // -------------------------------------------------------------------------
  localparam int TW = $clog2(TMO_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
  localparam logic [TW-1:0] TMO_PRE  = TW'(TMO_CYC - 2);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_restart;
  logic          tmo_hit;

  assign tmo_restart = push | pop | empty;
  assign tmo_hit     = ~tmo_restart & (tmo_cnt == TMO_PRE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
      tmo     <= 1'b0;
    end else begin
      if (tmo_restart) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_LAST) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      if (tmo_hit) begin
        tmo <= 1'b1;
      end else if (wr_stat && wr_data[3]) begin
        tmo <= 1'b0;
      end
    end
  end
`else
  // No timer in this build: TMO is constant 0 and never reaches irq.
  assign tmo = 1'b0;

  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TMO_CYC < 2) ^ wr_data[3];
`endif

  // Write-data bits with no register behind them.
  logic unused_wr_bits;
  assign unused_wr_bits = ^{wr_data[31:4], wr_data[1]};

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, receive FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TMO_CYC, default 1024, idle-timeout threshold in clk cycles (>=2).
REQ-003 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_end  in  1  one-cycle pulse from UART receiver: byte received.
REQ-006 SHALL have port rx_data  in  8  received byte, valid while rx_end=1.
REQ-007 SHALL have port cs_  in  1  bus chip select, active-low.
REQ-008 SHALL have port as_  in  1  bus address strobe, active-low, one cycle per access.
REQ-009 SHALL have port rw  in  1  1=read, 0=write.
REQ-010 SHALL have port addr  in  1  register select: 0=STATUS, 1=DATA.
REQ-011 SHALL have port wr_data  in  32  bus write data.
REQ-012 SHALL have port rd_data  out  32  bus read data, valid while rdy_=0.
REQ-013 SHALL have port rdy_  out  1  bus ready, active-low.
REQ-014 SHALL have port irq  out  1  level interrupt request, active-high.

Function
REQ-015 SHALL accept a bus access when cs_=0 and as_=0, then drive rdy_=0 for exactly the next cycle, with rd_data registered in that same cycle; rd_data SHALL be 0 whenever rdy_=1.
REQ-016 STATUS read SHALL return: bit0 IE, bit1 AVAIL (FIFO non-empty), bit2 OVR, bit3 TMO, bits[7:4] FIFO count, all other bits 0.
REQ-017 STATUS write SHALL load IE from wr_data[0]; writing 1 to bit2 or bit3 SHALL clear OVR or TMO respectively (W1C); writing 0 SHALL leave them unchanged.
REQ-018 DATA read SHALL return the head byte in bits[7:0], zero-extended, and pop it in the access cycle; a DATA read on an empty FIFO SHALL return 0 and not pop.
REQ-019 DATA write SHALL be ignored but still acknowledged with rdy_.
REQ-020 rx_end=1 with FIFO not full SHALL push rx_data; latency to AVAIL=1 SHALL be 1 cycle.
REQ-021 rx_end=1 with FIFO full SHALL drop the byte, leave FIFO contents unchanged, and set OVR.
REQ-022 Push and pop in the same cycle SHALL both take effect and leave the count unchanged; when full, the pop is applied first, so the push is accepted and OVR is not set.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH.
REQ-024 A set event and a W1C clear of the same flag in the same cycle SHALL leave the flag set.
REQ-025 irq SHALL equal IE & (AVAIL | OVR | TMO) and be registered, lagging the causing state by 1 cycle.

Reset
REQ-026 reset=0 SHALL immediately force: FIFO empty, pointers 0, IE=0, OVR=0, TMO=0, timeout counter 0, rdy_=1, rd_data=0, irq=0.
REQ-027 Reset asserted mid-access or mid-push SHALL abort it; no pending rdy_ SHALL be issued after release.

Configuration
REQ-028 With UART_RX_TIMEOUT_EN defined, a counter SHALL run while the FIFO is non-empty, SHALL clear on any push or pop or when empty, and SHALL set TMO and hold when it reaches TMO_CYC-1.
REQ-029 With UART_RX_TIMEOUT_EN undefined, no counter SHALL exist, TMO SHALL read 0, and TMO SHALL not contribute to irq.

Verification
REQ-030 Push 0x41 with IE=1 -> STATUS reads 0x13, irq=1 after 2 cycles, and a DATA read returns 0x41 with AVAIL then 0 and irq=0.
REQ-031 Push DEPTH+1 bytes 0x01..0x05 (DEPTH=4) -> OVR=1, count=4, and DATA reads return 0x01..0x04.
REQ-032 Full FIFO, rx_end coincident with DATA read -> OVR stays 0, count stays 4, and the new byte is read last.
REQ-033 Set OVR, then write STATUS 0x05 -> OVR=0 and IE=1.
REQ-034 With UART_RX_TIMEOUT_EN, TMO_CYC=16, push one byte and idle -> TMO=1 in the 16th cycle after the push; with the macro undefined, TMO stays 0.
REQ-035 Drive reset=0 while count=3 and an access is pending -> count=0, rdy_=1 and irq=0 with no clock edge required.
